// File: rtl/mul_approx_pkg.sv
// mul_approx_pkg: shared mode constants and arithmetic helpers for the approximate multiplier
package mul_approx_pkg;
  localparam logic MODE_EXACT = 1'b0;
  localparam logic MODE_TRUNC = 1'b1;
  localparam int MAX_PW = 64;
  function automatic logic col_keep(input int k, input int trunc_cols);
    return k >= trunc_cols;
  endfunction
  function automatic logic [MAX_PW-1:0] sat_add(input logic [MAX_PW-1:0] x, input logic [MAX_PW-1:0] c, input int w);
    logic [MAX_PW-1:0] s, m;
    s = x + c;
    m = (MAX_PW'(1) << w) - MAX_PW'(1);
    return (s > m) ? m : s;
  endfunction
endpackage

// File: rtl/mul_approx_ppgen.sv
// mul_approx_ppgen: masked per-column partial-product ones-counts (a,b,mode -> cols)
module mul_approx_ppgen
  import mul_approx_pkg::*;
#(
  parameter int W = 8,
  parameter int TRUNC_COLS = 5,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]             a,
  input  logic [W-1:0]             b,
  input  logic                     mode,
  output logic [2*W-1:0][CW-1:0]   cols
);
  always_comb begin
    cols = '0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (col_keep(i + j, mode == MODE_TRUNC ? TRUNC_COLS : 0))
          cols[i+j] = cols[i+j] + CW'(a[i] & b[j]);
  end
endmodule

// File: rtl/mul_approx_pipe.sv
// mul_approx_pipe: pipelined exact/approximate WxW multiplier with valid/ready and approx-op counter
module mul_approx_pipe
  import mul_approx_pkg::*;
#(
  parameter int          W          = 8,
  parameter int          STAGES     = 2,
  parameter int          TRUNC_COLS = 5,
  parameter int unsigned COMP       = 32,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_p,
  output logic             out_mode,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] approx_cnt
);
  localparam int PW = 2 * W;
  localparam int CW = $clog2(W + 1);
  localparam int NR = STAGES > 1 ? STAGES - 1 : 1;
  logic [PW-1:0][CW-1:0] cols, fin_cols;
  logic [PW-1:0][CW-1:0] r_cols [NR];
  logic [NR-1:0] r_vld, r_mode, r_zero;
  logic fin_vld, fin_mode, fin_zero, in_zero;
  logic [PW-1:0] prod, fin_p;
  assign in_ready = !out_valid | out_ready;
  assign in_zero = (in_a == '0) | (in_b == '0);
  mul_approx_ppgen #(.W(W), .TRUNC_COLS(TRUNC_COLS), .CW(CW)) u_ppgen (
    .a(in_a),
    .b(in_b),
    .mode(in_mode),
    .cols(cols)
  );
  assign fin_cols = STAGES == 1 ? cols : r_cols[NR-1];
  assign fin_vld = STAGES == 1 ? in_valid : r_vld[NR-1];
  assign fin_mode = STAGES == 1 ? in_mode : r_mode[NR-1];
  assign fin_zero = STAGES == 1 ? in_zero : r_zero[NR-1];
  always_comb begin
    prod = '0;
    for (int k = 0; k < PW; k++)
      prod = prod + (PW'(fin_cols[k]) << k);
  end
  assign fin_p = fin_zero ? '0
               : fin_mode == MODE_TRUNC ? PW'(sat_add(MAX_PW'(prod), MAX_PW'(COMP), PW))
               : prod;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_mode <= '0;
      r_zero <= '0;
      for (int k = 0; k < NR; k++) r_cols[k] <= '0;
      out_valid <= 1'b0;
      out_p <= '0;
      out_mode <= 1'b0;
    end else if (in_ready) begin
      r_vld[0] <= in_valid;
      r_mode[0] <= in_mode;
      r_zero[0] <= in_zero;
      r_cols[0] <= cols;
      for (int k = 1; k < NR; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_mode[k] <= r_mode[k-1];
        r_zero[k] <= r_zero[k-1];
        r_cols[k] <= r_cols[k-1];
      end
      out_valid <= fin_vld;
      out_p <= fin_p;
      out_mode <= fin_mode;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) approx_cnt <= '0;
    else if (cnt_clr) approx_cnt <= '0;
    else if (in_valid & in_ready & (in_mode == MODE_TRUNC) & (approx_cnt != '1))
      approx_cnt <= approx_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_mul_approx_pipe.sv
// tb_mul_approx_pipe: directed self-checking bench for mul_approx_pipe (default and exact-equivalent builds)
module tb_mul_approx_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic v0 = 0, m0 = 0, ordy0 = 1, clr0 = 0;
  logic [7:0] a0 = 0, b0 = 0;
  logic in_ready0, out_valid0, out_mode0;
  logic [15:0] out_p0, approx_cnt0;
  logic v1 = 0, m1 = 0, ordy1 = 1, clr1 = 0;
  logic [7:0] a1 = 0, b1 = 0;
  logic in_ready1, out_valid1, out_mode1;
  logic [15:0] out_p1;
  logic [1:0] approx_cnt1;
  mul_approx_pipe u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(in_ready0), .in_a(a0), .in_b(b0),
    .in_mode(m0), .out_valid(out_valid0), .out_ready(ordy0), .out_p(out_p0),
    .out_mode(out_mode0), .cnt_clr(clr0), .approx_cnt(approx_cnt0)
  );
  mul_approx_pipe #(.STAGES(3), .TRUNC_COLS(0), .COMP(0), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(in_ready1), .in_a(a1), .in_b(b1),
    .in_mode(m1), .out_valid(out_valid1), .out_ready(ordy1), .out_p(out_p1),
    .out_mode(out_mode1), .cnt_clr(clr1), .approx_cnt(approx_cnt1)
  );
  logic [7:0]  sa [8] = '{8'd1, 8'd10, 8'd255, 8'd3, 8'd16, 8'd255, 8'd0, 8'd100};
  logic [7:0]  sb [8] = '{8'd1, 8'd20, 8'd1, 8'd3, 8'd16, 8'd255, 8'd200, 8'd100};
  logic        sm [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [15:0] se [8] = '{16'd1, 16'd200, 16'd255, 16'd32, 16'd288, 16'd64928, 16'd0, 16'd10000};
  logic [15:0] rp [8];
  logic        rm [8];
  logic [15:0] q [$];
  logic [15:0] held;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tx0(input logic [7:0] a, input logic [7:0] b, input logic m, input logic [15:0] exp, input string tag);
    v0 = 1; a0 = a; b0 = b; m0 = m;
    @(posedge clk); #1;
    v0 = 0;
    chk({tag, "_early"}, out_valid0, 0);
    @(posedge clk); #1;
    chk({tag, "_vld"}, out_valid0, 1);
    chk({tag, "_p"}, out_p0, exp);
    chk({tag, "_mode"}, out_mode0, m);
  endtask
  initial begin
    int idx, n, sent, got;
    #2;
    chk("rst_vld", out_valid0, 0);
    chk("rst_p", out_p0, 0);
    chk("rst_mode", out_mode0, 0);
    chk("rst_cnt", approx_cnt0, 0);
    chk("rst_rdy", in_ready0, 1);
    #10 rst_n = 1;
    @(posedge clk); #1;
    tx0(8'd255, 8'd255, 1'b0, 16'd65025, "ex255");
    tx0(8'd255, 8'd255, 1'b1, 16'd64928, "ap255");
    tx0(8'd3, 8'd3, 1'b1, 16'd32, "ap3");
    tx0(8'd16, 8'd16, 1'b1, 16'd288, "ap16");
    tx0(8'd0, 8'd200, 1'b1, 16'd0, "ap0");
    chk("cnt4", approx_cnt0, 4);
    @(posedge clk); #1;
    idx = 0; n = 0;
    for (int c = 0; c < 24; c++) begin
      ordy0 = !(c >= 4 && c <= 6);
      v0 = idx < 8;
      if (idx < 8) begin a0 = sa[idx]; b0 = sb[idx]; m0 = sm[idx]; end
      #4;
      if (c == 4) held = out_p0;
      if (c >= 4 && c <= 6) begin
        chk("stall_vld", out_valid0, 1);
        chk("stall_rdy", in_ready0, 0);
      end
      if (c == 5 || c == 6) chk("stall_hold", out_p0, held);
      if (out_valid0 && ordy0) begin
        if (n < 8) begin rp[n] = out_p0; rm[n] = out_mode0; end
        n++;
      end
      if (v0 && in_ready0) idx++;
      @(posedge clk); #1;
    end
    v0 = 0; ordy0 = 1;
    chk("strm_n", n, 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("strm_p%0d", k), rp[k], se[k]);
      chk($sformatf("strm_m%0d", k), rm[k], sm[k]);
    end
    chk("cnt8", approx_cnt0, 8);
    clr0 = 1;
    @(posedge clk); #1;
    clr0 = 0;
    chk("clr0", approx_cnt0, 0);
    v1 = 1; a1 = 8'd200; b1 = 8'd201; m1 = 1;
    @(posedge clk); #1;
    v1 = 0;
    chk("u1_lat1", out_valid1, 0);
    chk("u1_cnt1", approx_cnt1, 1);
    @(posedge clk); #1;
    chk("u1_lat2", out_valid1, 0);
    @(posedge clk); #1;
    chk("u1_lat3", out_valid1, 1);
    chk("u1_p", out_p1, 40200);
    @(posedge clk); #1;
    sent = 0; got = 0;
    for (int c = 0; c < 1100 && got < 1000; c++) begin
      if (sent < 1000) begin
        v1 = 1; a1 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255));
      end else v1 = 0;
      #4;
      if (out_valid1) begin
        if (q.size() == 0) chk("rnd_extra", out_valid1, 0);
        else begin chk("rnd_p", out_p1, q.pop_front()); got++; end
      end
      if (v1 && in_ready1) begin q.push_back(16'(a1) * 16'(b1)); sent++; end
      @(posedge clk); #1;
    end
    v1 = 0;
    chk("rnd_got", got, 1000);
    chk("u1_sat", approx_cnt1, 3);
    clr1 = 1;
    @(posedge clk); #1;
    clr1 = 0;
    chk("u1_clr", approx_cnt1, 0);
    for (int k = 1; k <= 5; k++) begin
      v1 = 1; a1 = 8'(k); b1 = 8'd7;
      @(posedge clk); #1;
      chk($sformatf("u1_cnt_%0d", k), approx_cnt1, k > 3 ? 3 : k);
    end
    clr1 = 1;
    @(posedge clk); #1;
    clr1 = 0; v1 = 0;
    chk("u1_clr_pri", approx_cnt1, 0);
    v0 = 1; a0 = 8'd255; b0 = 8'd255; m0 = 1;
    @(posedge clk); #1;
    a0 = 8'd3; b0 = 8'd3;
    @(posedge clk); #1;
    v0 = 0;
    chk("pre_rst_vld", out_valid0, 1);
    chk("pre_rst_cnt", approx_cnt0, 2);
    #1 rst_n = 0;
    #1;
    chk("arst_vld", out_valid0, 0);
    chk("arst_cnt", approx_cnt0, 0);
    chk("arst_p", out_p0, 0);
    @(posedge clk); #2;
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("no_stale", out_valid0, 0);
    end
    tx0(8'd7, 8'd9, 1'b0, 16'd63, "post_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_approx_pipe.md
Name: mul_approx_pipe

Overview:
- Parametrised, pipelined unsigned WxW multiplier with a per-transaction mode: exact, or approximate via column truncation plus a constant compensation term.
- Successor to the fixed 8x8 combinational approximate multipliers in the library. Adds a valid/ready handshake, configurable latency and a saturating counter of approximate operations.
- Sits between operand producers and accumulate/filter datapaths in FPGA power/error exploration builds.

Parameters:
- W, 8: operand width in bits; the product is 2W bits.
- STAGES, 2: pipeline depth, 1..4, equal to the latency in cycles.
- TRUNC_COLS, 5: partial-product columns 0..TRUNC_COLS-1 are discarded in approximate mode; range 0..2W-1.
- COMP, 32: constant added to the truncated sum in approximate mode; must be < 2^(2W).
- CNT_W, 16: width of the approximate-operation counter.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- in_valid, in, 1: operand transfer valid.
- in_ready, out, 1: block can accept operands.
- in_a, in, W: multiplicand.
- in_b, in, W: multiplier.
- in_mode, in, 1: 0 = exact, 1 = approximate; sampled together with the operands.
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accepts the result.
- out_p, out, 2W: product.
- out_mode, out, 1: mode carried with the result.
- cnt_clr, in, 1: synchronous clear of approx_cnt.
- approx_cnt, out, CNT_W: count of accepted approximate transactions, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous): all stage valid bits, out_valid, out_p, out_mode and approx_cnt go to 0. A transaction in flight is dropped with no output.
- Handshake:
  - Acceptance occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - out_p and out_mode hold stable while out_valid & !out_ready.
- Flow control: global stall. in_ready = !out_valid | out_ready, purely combinational from registered state and out_ready. The whole pipeline advances only when in_ready=1. Bubbles propagate as invalid stages.
- Latency: an operand accepted at edge t gives out_valid=1 after edge t+STAGES-1, provided no stall occurs. Throughput is 1 per cycle when out_ready is held at 1.
- Arithmetic, exact mode: out_p = in_a * in_b, full 2W bits.
- Arithmetic, approximate mode:
  - S = sum over i,j of a_i·b_j·2^(i+j), taken only for terms with i+j >= TRUNC_COLS.
  - out_p = min(S + COMP, 2^(2W)-1); the add is computed at 2W+1 bits and then saturated.
- Zero rule: if in_a==0 or in_b==0, out_p = 0 in both modes, so no compensation is applied.
- TRUNC_COLS=0 with COMP=0 makes approximate mode equal to exact; this must hold bit-exactly.
- Stage split:
  - Stage 1 registers the partial-product column sums with the mask applied.
  - The final adder, compensation and saturation are placed in the last stage.
  - Intermediate stages are register-only retiming slots. Behaviour is invariant to STAGES except latency.
- Counter:
  - Increments by 1 on each acceptance with in_mode=1.
  - Saturates at 2^CNT_W-1.
  - cnt_clr=1 forces 0 at the next edge, with priority over a simultaneous increment.
- Mode and operands are captured only at acceptance. Input changes while in_ready=0 have no effect.

Decomposition:
- Package mul_approx_pkg:
  - MODE_EXACT=1'b0 and MODE_TRUNC=1'b1 constants.
  - Function col_keep(k, trunc_cols) returning the column-mask bit.
  - Function sat_add(x, c, w) giving a 2W-bit saturating add.
- One sub-module, mul_approx_ppgen: combinational W x W partial-product generator with column mask. It outputs per-column ones-counts or a compressed sum, and is instantiated once in stage 1.

Test Plan:
- W=8 defaults, out_ready=1, exact mode, A=255, B=255 -> out_p=65025 exactly 2 cycles after acceptance, out_mode=0.
- Approximate mode, A=255, B=255 -> out_p=64928 (65025-129+32); A=3, B=3 -> 32; A=16, B=16 -> 288; A=0, B=200 -> 0. approx_cnt=4 afterwards.
- Back-to-back stream of 8 operand pairs with out_ready low for 3 cycles mid-stream -> in_ready low during the stall, out_p held stable, all 8 results delivered in order with none lost or duplicated.
- Parameter build TRUNC_COLS=0, COMP=0, STAGES=3 -> 1000 random pairs in approximate mode match A*B; latency 3.
- Build CNT_W=2: issue 5 approximate accepts -> approx_cnt saturates at 3. Then assert cnt_clr in the same cycle as an approximate accept -> approx_cnt=0.
- Assert rst_n low for 1 cycle with 2 transactions in flight -> out_valid=0, approx_cnt=0 immediately (asynchronous); no stale result appears after release.
